// File: rtl/simon_pkg.sv
// simon_pkg: shared state encoding and parameter defaults for simon_control
package simon_pkg;
    typedef enum logic [2:0] {
        ST_INIT,
        ST_INPUT,
        ST_PLAYBACK,
        ST_REPEAT,
        ST_DONE
    } state_t;
    localparam int MAX_ROUNDS_DEF = 63;
    localparam int PLAYBACK_TICKS_DEF = 25_000_000;
endpackage

// File: rtl/simon_btn_sync.sv
// simon_btn_sync: two-flop synchroniser plus rising-edge detector; ports clk, rst (async high), next (raw button) -> next_pulse (one cycle per press)
module simon_btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic next,
    output logic next_pulse
);
    logic s1, s2, prev;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {s1, s2, prev} <= '0;
        else     {s1, s2, prev} <= {next, s1, s2};
    end
    assign next_pulse = s2 & ~prev;
endmodule

// File: rtl/simon_control.sv
// simon_control: Simon game controller FSM; in clk, rst (async high), next, right_guess, i_eq_ns, legal; out reset, rst_i, count_i, count_ns, m1..m4 (INPUT/PLAYBACK/REPEAT/DONE), won; SIMON_PLAYBACK_TIMER_EN makes playback/done advance on a PLAYBACK_TICKS timer instead of next
module simon_control
    import simon_pkg::*;
#(
    parameter int PLAYBACK_TICKS = PLAYBACK_TICKS_DEF,
    parameter int MAX_ROUNDS     = MAX_ROUNDS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic next,
    input  logic right_guess,
    input  logic i_eq_ns,
    input  logic legal,
    output logic reset,
    output logic rst_i,
    output logic count_i,
    output logic count_ns,
    output logic m1,
    output logic m2,
    output logic m3,
    output logic m4,
    output logic won
);
    state_t state, nxt;
    logic [5:0] rounds;
    logic next_pulse, adv, win_set;
    simon_btn_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .next       (next),
        .next_pulse (next_pulse)
    );
`ifdef SIMON_PLAYBACK_TIMER_EN
    logic [31:0] timer;
    assign adv = timer == 32'(PLAYBACK_TICKS - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) timer <= '0;
        else     timer <= (nxt != state || adv || !(state inside {ST_PLAYBACK, ST_DONE})) ? '0 : timer + 32'd1;
    end
`else
    assign adv = next_pulse;
`endif
    always_comb begin
        nxt      = state;
        rst_i    = 1'b0;
        count_i  = 1'b0;
        count_ns = 1'b0;
        win_set  = 1'b0;
        case (state)
            ST_INIT: nxt = ST_INPUT;
            ST_INPUT: begin
                count_ns = next_pulse && legal;
                rst_i    = count_ns;
                win_set  = count_ns && rounds == 6'(MAX_ROUNDS - 1);
                nxt      = win_set ? ST_DONE : count_ns ? ST_PLAYBACK : ST_INPUT;
            end
            ST_PLAYBACK: begin
                rst_i   = i_eq_ns;
                count_i = !i_eq_ns && adv;
                nxt     = i_eq_ns ? ST_REPEAT : ST_PLAYBACK;
            end
            ST_REPEAT: begin
                rst_i   = i_eq_ns || (next_pulse && !right_guess);
                count_i = !i_eq_ns && next_pulse && right_guess;
                nxt     = i_eq_ns ? ST_INPUT : (next_pulse && !right_guess) ? ST_DONE : ST_REPEAT;
            end
            ST_DONE: begin
                rst_i   = i_eq_ns;
                count_i = !i_eq_ns && adv;
            end
            default: nxt = ST_INIT;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_INIT;
            rounds <= '0;
            won    <= 1'b0;
            reset  <= 1'b1;
            {m4, m3, m2, m1} <= '0;
        end else begin
            state  <= nxt;
            rounds <= state == ST_INIT ? '0 : rounds + {5'd0, count_ns};
            won    <= won | win_set;
            reset  <= nxt == ST_INIT;
            m1     <= nxt == ST_INPUT;
            m2     <= nxt == ST_PLAYBACK;
            m3     <= nxt == ST_REPEAT;
            m4     <= nxt == ST_DONE;
        end
    end
endmodule

// File: tb/tb_simon_control.sv
// tb_simon_control: self-checking bench for simon_control
module tb_simon_control;
    logic clk = 1'b0, rst = 1'b1, next = 1'b0, right_guess = 1'b0, i_eq_ns = 1'b0, legal = 1'b0;
    logic reset, rst_i, count_i, count_ns, m1, m2, m3, m4, won;
    int n_tests = 0, n_fail = 0;
`ifdef SIMON_PLAYBACK_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif
    typedef struct {
        int hold; int eq_cyc; int n;
        logic legal; logic rg;
        int e_ns; int e_ri; int e_ci;
        int e_mode; int e_won;
    } op_t;
    op_t ops[14];
    op_t sbq[$];
    simon_control #(.PLAYBACK_TICKS(4), .MAX_ROUNDS(63)) dut (
        .clk(clk), .rst(rst), .next(next), .right_guess(right_guess), .i_eq_ns(i_eq_ns), .legal(legal),
        .reset(reset), .rst_i(rst_i), .count_i(count_i), .count_ns(count_ns),
        .m1(m1), .m2(m2), .m3(m3), .m4(m4), .won(won)
    );
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
    function automatic int md();
        return int'({m4, m3, m2, m1});
    endfunction
    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic after_release();
        @(negedge clk);
        chk("init_reset", reset, 1);
        chk("init_mode", md(), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("input_reset", reset, 0);
        chk("input_mode", md(), 1);
        @(posedge clk); #1;
    endtask
    task automatic run_op(input op_t o, output int ns, output int ri, output int ci, output int bad,
                          output int mode, output int w);
        ns = 0; ri = 0; ci = 0; bad = 0; mode = 0; w = 0;
        legal = o.legal; right_guess = o.rg;
        for (int c = 0; c < o.n; c++) begin
            next = c < o.hold;
            i_eq_ns = c < o.eq_cyc;
            @(negedge clk);
            ns += int'(count_ns); ri += int'(rst_i); ci += int'(count_i); bad += int'(rst_i & count_i);
            mode = md(); w = int'(won);
            @(posedge clk); #1;
        end
        next = 0; i_eq_ns = 0;
    endtask
    task automatic press(output logic got);
        got = 1'b0; legal = 1'b1; next = 1'b1;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            got = count_ns & rst_i;
            @(posedge clk); #1;
            next = 1'b0;
        end
        next = 1'b0;
    endtask
    initial begin
        int ns, ri, ci, bad, mode, w;
        logic got;
        op_t e;
        ops[0]  = '{10, 0, 14, 1'b0, 1'b0, 0, 0, 0, 1, 0};
        ops[1]  = '{10, 0, 14, 1'b1, 1'b0, 1, 1, 0, 2, 0};
        ops[2]  = '{2, 0, 5, 1'b0, 1'b0, 0, 0, 1, 2, 0};
        ops[3]  = '{2, 0, 5, 1'b0, 1'b0, 0, 0, 1, 2, 0};
        ops[4]  = '{2, 0, 5, 1'b0, 1'b0, 0, 0, 1, 2, 0};
        ops[5]  = '{0, 1, 2, 1'b0, 1'b0, 0, 1, 0, 4, 0};
        ops[6]  = '{2, 0, 5, 1'b0, 1'b1, 0, 0, 1, 4, 0};
        ops[7]  = '{0, 1, 2, 1'b0, 1'b0, 0, 1, 0, 1, 0};
        ops[8]  = '{2, 0, 5, 1'b1, 1'b0, 1, 1, 0, 2, 0};
        ops[9]  = '{0, 1, 2, 1'b0, 1'b0, 0, 1, 0, 4, 0};
        ops[10] = '{2, 0, 5, 1'b0, 1'b0, 0, 1, 0, 8, 0};
        ops[11] = '{2, 0, 5, 1'b0, 1'b0, 0, 0, 1, 8, 0};
        ops[12] = '{0, 1, 2, 1'b0, 1'b0, 0, 1, 0, 8, 0};
        ops[13] = '{2, 0, 5, 1'b1, 1'b1, 0, 0, 1, 8, 0};
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_reset", reset, 1);
        chk("rst_mode", md(), 0);
        chk("rst_ctl", int'({rst_i, count_i, count_ns}), 0);
        chk("rst_won", won, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        after_release();
`ifndef SIMON_PLAYBACK_TIMER_EN
        foreach (ops[i]) begin
            sbq.push_back(ops[i]);
            run_op(ops[i], ns, ri, ci, bad, mode, w);
            e = sbq.pop_front();
            chk($sformatf("op%0d_count_ns", i), ns, e.e_ns);
            chk($sformatf("op%0d_rst_i", i), ri, e.e_ri);
            chk($sformatf("op%0d_count_i", i), ci, e.e_ci);
            chk($sformatf("op%0d_mode", i), mode, e.e_mode);
            chk($sformatf("op%0d_won", i), w, e.e_won);
            chk($sformatf("op%0d_ri_ci_overlap", i), bad, 0);
        end
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        after_release();
        press(got);
        chk("pl_press", got, 1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("pl_ci_%0d", k), count_i, TMR ? int'(k % 4 == 0) : 0);
            chk($sformatf("pl_mode_%0d", k), md(), 2);
        end
        @(posedge clk); #1;
        i_eq_ns = 1'b1; next = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("abort_reset", reset, 1);
        chk("abort_mode", md(), 0);
        chk("abort_ctl", int'({rst_i, count_i, count_ns}), 0);
        chk("abort_won", won, 0);
        @(posedge clk); #1;
        rst = 1'b0; i_eq_ns = 1'b0; next = 1'b0;
        after_release();
        bad = 0;
        for (int r = 0; r < 63; r++) begin
            press(got);
            if (!got) bad++;
            @(negedge clk);
            if (md() != (r < 62 ? 2 : 8)) bad++;
            if (int'(won) != int'(r == 62)) bad++;
            @(posedge clk); #1;
            if (r < 62) begin
                i_eq_ns = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                i_eq_ns = 1'b0;
            end
        end
        chk("win_path_errors", bad, 0);
        @(negedge clk);
        chk("win_mode", md(), 8);
        chk("win_won", won, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/simon_control.md
SIMON_CONTROL -- requirements
Module: simon_control

Interface
REQ-001 Parameter PLAYBACK_TICKS, default 25000000, clk cycles each stored entry is shown during playback/done display (timer build only).
REQ-002 Parameter MAX_ROUNDS, default 63, highest count of stored entries before forced win.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 next  input  1  raw, unsynchronised player push-button.
REQ-006 right_guess / i_eq_ns / legal  input  1 each  datapath status flags, combinational from datapath.
REQ-007 reset  output  1  datapath global reset (clears i, ns; samples level).
REQ-008 rst_i / count_i / count_ns  output  1 each  datapath index clear, index increment, sequence-count increment.
REQ-009 m1 / m2 / m3 / m4  output  1 each  one-hot mode: INPUT / PLAYBACK / REPEAT / DONE.
REQ-010 won  output  1  high in DONE only when entered via MAX_ROUNDS.

Function
REQ-011 States INIT, INPUT, PLAYBACK, REPEAT, DONE; m1..m4 and reset are Moore outputs; rst_i, count_i, count_ns are Mealy, valid in the same cycle as the deciding inputs.
REQ-012 next passes a two-flop synchroniser; next_pulse is high for exactly one cycle when synced level is 1 and its previous sample was 0; held button yields one pulse.
REQ-013 INIT: reset=1 for exactly one cycle, then INPUT unconditionally.
REQ-014 INPUT: on next_pulse with legal=1 -> count_ns=1, rst_i=1, rounds+1, go PLAYBACK; next_pulse with legal=0 is ignored, state unchanged.
REQ-015 INPUT: accepted press when rounds==MAX_ROUNDS-1 -> count_ns=1, rst_i=1, set won, go DONE instead of PLAYBACK.
REQ-016 PLAYBACK: if i_eq_ns -> rst_i=1, go REPEAT (priority over advance); else on advance event -> count_i=1.
REQ-017 REPEAT: if i_eq_ns -> rst_i=1, go INPUT; else on next_pulse: right_guess=1 -> count_i=1, stay; right_guess=0 -> rst_i=1, go DONE, won stays 0.
REQ-018 DONE: on advance event -> count_i=1; if i_eq_ns -> rst_i=1 (wrap to entry 0); terminal until rst.
REQ-019 rst_i and count_i never both 1 in one cycle; rst_i wins.
REQ-020 rounds is an internal 6-bit counter, cleared in INIT, never wraps (bounded by REQ-015).

Reset
REQ-021 rst asserted -> immediately state=INIT, rounds=0, won=0, synchroniser and edge flops=0, timer=0; outputs reset=1, all others 0.
REQ-022 rst asserted mid-game in any state aborts with no further count pulses; after release sequence restarts at REQ-013.

Configuration
REQ-023 Macro SIMON_PLAYBACK_TIMER_EN defined: advance event = internal timer reaching PLAYBACK_TICKS-1 (timer clears on state entry and on each advance); next_pulse ignored in PLAYBACK and DONE.
REQ-024 Macro undefined: advance event = next_pulse; no timer logic instantiated; PLAYBACK_TICKS unused.

Structure
REQ-025 Shared package simon_pkg holds state encoding constants, MAX_ROUNDS default and PLAYBACK_TICKS default.
REQ-026 One sub-module simon_btn_sync implements synchroniser plus rising-edge detector (REQ-012).

Verification
REQ-027 Release rst -> reset=1 exactly one cycle, then m1=1; next held high 10 cycles -> one count_ns pulse only.
REQ-028 INPUT, legal=0, next pulse -> no count_ns, m1 stays 1; legal=1 pulse -> count_ns=1 and rst_i=1 same cycle, m2=1 next cycle.
REQ-029 Macro undefined, PLAYBACK with i_eq_ns=0, three next pulses -> three single-cycle count_i; i_eq_ns=1 -> rst_i=1, m3=1 next cycle.
REQ-030 REPEAT, next pulse with right_guess=0 -> rst_i=1, m4=1, won=0; later next pulses cycle count_i, rst_i when i_eq_ns=1.
REQ-031 Macro defined, PLAYBACK_TICKS=4 -> count_i every 4 cycles in PLAYBACK; 63 accepted rounds -> DONE with won=1; rst mid-PLAYBACK -> outputs per REQ-021 same cycle.
